// File: rtl/if_queue_pkg.sv
//------------------------------------------------------------------------------
// if_queue_pkg : shared fetch/decode pipeline definitions for the queue
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package if_queue_pkg;

  localparam int IFQ_XLEN       = 32;
  localparam int IFQ_EXC_CODE_W = 4;

  // addi x0, x0, 0
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [IFQ_EXC_CODE_W-1:0] {
    EXC_INSTR_MISALIGN    = 4'd0,
    EXC_INSTR_ACCESS      = 4'd1,
    EXC_ILLEGAL_INSTR     = 4'd2,
    EXC_BREAKPOINT        = 4'd3,
    EXC_LOAD_MISALIGN     = 4'd4,
    EXC_LOAD_ACCESS       = 4'd5,
    EXC_STORE_MISALIGN    = 4'd6,
    EXC_STORE_ACCESS      = 4'd7,
    EXC_ECALL_U           = 4'd8,
    EXC_ECALL_S           = 4'd9,
    EXC_ECALL_M           = 4'd11,
    EXC_INSTR_PAGE_FAULT  = 4'd12,
    EXC_LOAD_PAGE_FAULT   = 4'd13,
    EXC_STORE_PAGE_FAULT  = 4'd15
  } type_exc_code_e;

  typedef struct packed {
    logic [IFQ_XLEN-1:0] pc;
    logic [31:0]         instr;
    logic                exc_req;
    type_exc_code_e      exc_code;
    logic                irq_req;
  } type_ifq_entry_s;

endpackage

`default_nettype wire

// File: rtl/if_queue_mem.sv
//------------------------------------------------------------------------------
// ifq_mem : DEPTH-entry register array, one sync write port, one comb read port
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ifq_mem
  import if_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  type_ifq_entry_s wdata,
  input  logic [AW-1:0]   raddr,
  output type_ifq_entry_s rdata
);

  // Contents are meaningless until written, so the array carries no reset.
  type_ifq_entry_s mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/if_queue.sv
//------------------------------------------------------------------------------
// if_queue : fetch-to-decode instruction queue with fence on exc/irq and flush
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module if_queue
  import if_queue_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int XLEN       = 32,
  parameter int EXC_CODE_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic                      if_valid_i,
  output logic                      if_ready_o,
  input  logic [XLEN-1:0]           if_pc_i,
  input  logic [31:0]               if_instr_i,
  input  logic                      if_exc_req_i,
  input  logic [EXC_CODE_W-1:0]     if_exc_code_i,
  input  logic                      if_irq_req_i,
  output logic                      id_valid_o,
  input  logic                      id_ready_i,
  output logic [XLEN-1:0]           id_pc_o,
  output logic [31:0]               id_instr_o,
  output logic                      id_exc_req_o,
  output logic [EXC_CODE_W-1:0]     id_exc_code_o,
  output logic                      id_irq_req_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   count;
  logic            fence;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  type_ifq_entry_s wdata;
  type_ifq_entry_s rdata;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // Ready is purely registered state so fetch never sees a path from decode.
  assign if_ready_o = ~full & ~fence;
  assign id_valid_o = ~empty & ~flush_i;

  assign push = if_valid_i & if_ready_o & ~flush_i;
  assign pop  = id_valid_o & id_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      fence  <= 1'b0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      fence  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + {{(PW-1){1'b0}}, push} - {{(PW-1){1'b0}}, pop};
      // A trapping entry must be the last one decode sees until the redirect.
      if (push && (if_exc_req_i || if_irq_req_i)) begin
        fence <= 1'b1;
      end
    end
  end

  always_comb begin
    wdata          = '0;
    wdata.pc       = if_pc_i;
    wdata.instr    = if_instr_i;
    wdata.exc_req  = if_exc_req_i;
    wdata.exc_code = type_exc_code_e'(if_exc_code_i);
    wdata.irq_req  = if_irq_req_i;
  end

  ifq_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  assign id_pc_o       = empty ? '0        : rdata.pc;
  assign id_instr_o    = empty ? INSTR_NOP : rdata.instr;
  assign id_exc_req_o  = empty ? 1'b0      : rdata.exc_req;
  assign id_exc_code_o = empty ? '0        : rdata.exc_code;
  assign id_irq_req_o  = empty ? 1'b0      : rdata.irq_req;
  assign count_o       = count;

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
  a_count_ptrs:   assert property (@(posedge clk) disable iff (!rst_n)
                                   count == PW'(wr_ptr - rd_ptr));

endmodule

`default_nettype wire

// File: tb/tb_if_queue.sv
//------------------------------------------------------------------------------
// tb_if_queue : directed + random stimulus against a queue-based reference model
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_if_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
    logic [3:0]  code;
    logic        irq;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        if_valid_i;
  logic        if_ready_o;
  logic [31:0] if_pc_i;
  logic [31:0] if_instr_i;
  logic        if_exc_req_i;
  logic [3:0]  if_exc_code_i;
  logic        if_irq_req_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;
  logic        id_exc_req_o;
  logic [3:0]  id_exc_code_o;
  logic        id_irq_req_o;
  logic [2:0]  count_o;

  int   checks = 0;
  int   errors = 0;
  ent_t q[$];
  bit   fence_m = 1'b0;

  always #5 clk = ~clk;

  if_queue #(.DEPTH(DEPTH), .XLEN(32), .EXC_CODE_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush_i),
    .if_valid_i    (if_valid_i),
    .if_ready_o    (if_ready_o),
    .if_pc_i       (if_pc_i),
    .if_instr_i    (if_instr_i),
    .if_exc_req_i  (if_exc_req_i),
    .if_exc_code_i (if_exc_code_i),
    .if_irq_req_i  (if_irq_req_i),
    .id_valid_o    (id_valid_o),
    .id_ready_i    (id_ready_i),
    .id_pc_o       (id_pc_o),
    .id_instr_o    (id_instr_o),
    .id_exc_req_o  (id_exc_req_o),
    .id_exc_code_o (id_exc_code_o),
    .id_irq_req_o  (id_irq_req_o),
    .count_o       (count_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit   ne;
    ent_t h;
    ne = (q.size() != 0);
    h  = ne ? q[0] : '{pc: 32'h0, instr: NOP, exc: 1'b0, code: 4'h0, irq: 1'b0};
    chk("if_ready", 64'(if_ready_o), 64'((q.size() < DEPTH) && !fence_m));
    chk("id_valid", 64'(id_valid_o), 64'(ne && !flush_i));
    chk("count",    64'(count_o),    64'(q.size()));
    chk("id_pc",    64'(id_pc_o),    64'(h.pc));
    chk("id_instr", 64'(id_instr_o), 64'(h.instr));
    chk("id_exc",   64'(id_exc_req_o), 64'(h.exc));
    chk("id_code",  64'(id_exc_code_o), 64'(h.code));
    chk("id_irq",   64'(id_irq_req_o), 64'(h.irq));
  endtask

  // One clock: drive after a negedge, check mid-cycle, advance model at posedge.
  task automatic cycle(input bit v, input logic [31:0] pc, input logic [31:0] instr,
                       input bit exc, input logic [3:0] code, input bit irq,
                       input bit rdy, input bit fl);
    bit do_push;
    bit do_pop;
    if_valid_i    = v;
    if_pc_i       = pc;
    if_instr_i    = instr;
    if_exc_req_i  = exc;
    if_exc_code_i = code;
    if_irq_req_i  = irq;
    id_ready_i    = rdy;
    flush_i       = fl;
    #1;
    check_outputs();
    do_push = v && (q.size() < DEPTH) && !fence_m && !fl;
    do_pop  = (q.size() != 0) && !fl && rdy;
    @(posedge clk);
    if (fl) begin
      q.delete();
      fence_m = 1'b0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back('{pc: pc, instr: instr, exc: exc, code: code, irq: irq});
        if (exc || irq) fence_m = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic push_pc(input logic [31:0] pc, input bit rdy);
    cycle(1'b1, pc, 32'h0010_0093 + pc, 1'b0, 4'h0, 1'b0, rdy, 1'b0);
  endtask

  task automatic idle(input bit rdy, input bit fl);
    cycle(1'b0, 32'h0, NOP, 1'b0, 4'h0, 1'b0, rdy, fl);
  endtask

  initial begin
    rst_n = 1'b0;
    flush_i = 1'b0; if_valid_i = 1'b0; if_pc_i = '0; if_instr_i = '0;
    if_exc_req_i = 1'b0; if_exc_code_i = '0; if_irq_req_i = 1'b0; id_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Fill to full, then drain in order.
    for (int i = 0; i < 4; i++) push_pc(32'h8000_0000 + 32'(4 * i), 1'b0);
    chk("full_count", 64'(count_o), 64'd4);
    chk("full_ready", 64'(if_ready_o), 64'd0);
    chk("full_head",  64'(id_pc_o), 64'h8000_0000);
    push_pc(32'h9000_0000, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    chk("drained_instr", 64'(id_instr_o), 64'(NOP));

    // Streaming push+pop, pointers wrap several times.
    push_pc(32'hA000_0000, 1'b0);
    for (int i = 1; i <= 20; i++) push_pc(32'hA000_0000 + 32'(4 * i), 1'b1);
    chk("stream_count", 64'(count_o), 64'd1);
    idle(1'b1, 1'b0);

    // Fence on exception, released only by flush.
    cycle(1'b1, 32'hB000_0000, 32'h0000_0073, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
    chk("fence_ready", 64'(if_ready_o), 64'd0);
    chk("fence_code",  64'(id_exc_code_o), 64'd12);
    push_pc(32'hB000_0004, 1'b0);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);
    chk("post_flush_ready", 64'(if_ready_o), 64'd1);

    // Flush colliding with push and pop.
    push_pc(32'hC000_0000, 1'b0);
    push_pc(32'hC000_0004, 1'b0);
    cycle(1'b1, 32'hC000_0008, 32'h1111_1111, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    chk("flush_count", 64'(count_o), 64'd0);
    idle(1'b1, 1'b0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 3; i++) push_pc(32'hD000_0000 + 32'(4 * i), 1'b0);
    if_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    fence_m = 1'b0;
    chk("arst_count", 64'(count_o), 64'd0);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom,
            $urandom_range(0, 15) == 0, 4'($urandom), $urandom_range(0, 19) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
